// File: rtl/pattern_pixel_stream.sv
// Expands header-prefixed pattern words from a show-ahead FIFO into 24-bit RGB pixels,
// with horizontal replication, mono/gray modes, inversion and one pattern per frame.
module pattern_pixel_stream #(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned FILL_W    = 8,
    parameter bit          VS_ACTIVE = 1'b0
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst,
    input  logic [DATA_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              pixel_de,
    input  logic              pixel_hs,
    input  logic              pixel_vs,
    input  logic              mode,
    input  logic              invert,
    output logic              gen_de,
    output logic              gen_hs,
    output logic              gen_vs,
    output logic [7:0]        gen_r,
    output logic [7:0]        gen_g,
    output logic [7:0]        gen_b,
    output logic              busy,
    output logic              pattern_done,
    output logic              all_done,
    output logic              underflow,
    output logic              hdr_err
);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, SYNC, STREAM} state_t;
    state_t state;

    logic [CNT_W-1:0]  total_pix, pix_left, pat_left, shift_cnt;
    logic [FILL_W-1:0] fill_m1, fill_cnt;
    logic              mode_q, invert_q;

    logic [CNT_W-1:0]  hdr_total, hdr_pat, p_last;
    logic [FILL_W-1:0] hdr_fill;
    logic [IDX_W-1:0]  bit_idx, byte_idx;
    logic [7:0]        pix_byte;
    logic [23:0]       color;
    logic              last_rep, last_pix, word_end, emit, frame_start;

    assign hdr_total = CNT_W'(word_data[DATA_W-65 -: 32]);
    assign hdr_pat   = CNT_W'(word_data[DATA_W-97 -: 32]);
    assign hdr_fill  = word_data[DATA_W-161+FILL_W -: FILL_W];

    assign p_last   = mode_q ? CNT_W'(DATA_W/8 - 1) : CNT_W'(DATA_W - 1);
    assign last_rep = (fill_cnt == fill_m1);
    assign last_pix = (pix_left == CNT_W'(1));
    assign word_end = (shift_cnt == p_last) || last_pix;
    assign emit     = (state == STREAM) && pixel_de && word_valid;
    // gen_vs holds the previous pixel_vs, so it doubles as the edge detector
    assign frame_start = (gen_vs == VS_ACTIVE) && (pixel_vs != VS_ACTIVE);

    assign word_ready = !pixel_rst &&
                        (((state == IDLE) && word_valid) || (emit && last_rep && word_end));
    assign busy = (state != IDLE);

    always_comb begin
        bit_idx  = IDX_W'(DATA_W - 1) - IDX_W'(shift_cnt);
        byte_idx = IDX_W'(DATA_W - 1) - (IDX_W'(shift_cnt) << 3);
        pix_byte = word_data[byte_idx -: 8];
        color    = mode_q ? {3{pix_byte}} : {24{~word_data[bit_idx]}};
        color    = color ^ {24{invert_q}};
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state        <= IDLE;
            gen_de       <= 1'b0;
            gen_hs       <= 1'b1;
            gen_vs       <= 1'b1;
            {gen_r, gen_g, gen_b} <= '0;
            pattern_done <= 1'b0;
            all_done     <= 1'b0;
            underflow    <= 1'b0;
            hdr_err      <= 1'b0;
            total_pix    <= '0;
            pix_left     <= '0;
            pat_left     <= '0;
            shift_cnt    <= '0;
            fill_m1      <= '0;
            fill_cnt     <= '0;
            mode_q       <= 1'b0;
            invert_q     <= 1'b0;
        end else begin
            gen_de       <= pixel_de;
            gen_hs       <= pixel_hs;
            gen_vs       <= pixel_vs;
            {gen_r, gen_g, gen_b} <= '0;
            pattern_done <= 1'b0;
            all_done     <= 1'b0;
            underflow    <= 1'b0;
            hdr_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (word_valid) begin
                        total_pix <= hdr_total;
                        pix_left  <= hdr_total;
                        pat_left  <= hdr_pat;
                        fill_m1   <= (hdr_fill == '0) ? '0 : hdr_fill - FILL_W'(1);
                        mode_q    <= mode;
                        invert_q  <= invert;
                        if (hdr_total == '0 || hdr_pat == '0)
                            hdr_err <= 1'b1;
                        else
                            state <= SYNC;
                    end
                end
                SYNC: begin
                    if (frame_start) begin
                        shift_cnt <= '0;
                        fill_cnt  <= '0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (pixel_de) begin
                        if (!word_valid) begin
                            underflow <= 1'b1;
                        end else begin
                            {gen_r, gen_g, gen_b} <= color;
                            if (last_rep) begin
                                fill_cnt  <= '0;
                                pix_left  <= pix_left - CNT_W'(1);
                                shift_cnt <= word_end ? '0 : shift_cnt + CNT_W'(1);
                                if (last_pix) begin
                                    pattern_done <= 1'b1;
                                    pat_left     <= pat_left - CNT_W'(1);
                                    if (pat_left == CNT_W'(1)) begin
                                        all_done <= 1'b1;
                                        state    <= IDLE;
                                    end else begin
                                        pix_left <= total_pix;
                                        state    <= SYNC;
                                    end
                                end
                            end else begin
                                fill_cnt <= fill_cnt + FILL_W'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_pixel_stream.sv
// Directed bench for pattern_pixel_stream: a pixel-index model checks every cycle,
// and per-scenario literal expectations pin pixel values, pulse counts and pop positions.
`timescale 1ns/1ps
module tb_pattern_pixel_stream;
    localparam int DATA_W = 256;

    logic              pixel_clk = 1'b0;
    logic              pixel_rst;
    logic [DATA_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              pixel_de, pixel_hs, pixel_vs, mode, invert;
    logic              gen_de, gen_hs, gen_vs;
    logic [7:0]        gen_r, gen_g, gen_b;
    logic              busy, pattern_done, all_done, underflow, hdr_err;

    pattern_pixel_stream #(.DATA_W(DATA_W), .CNT_W(32), .FILL_W(8), .VS_ACTIVE(1'b0)) dut (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .pixel_de(pixel_de), .pixel_hs(pixel_hs), .pixel_vs(pixel_vs),
        .mode(mode), .invert(invert),
        .gen_de(gen_de), .gen_hs(gen_hs), .gen_vs(gen_vs),
        .gen_r(gen_r), .gen_g(gen_g), .gen_b(gen_b),
        .busy(busy), .pattern_done(pattern_done), .all_done(all_done),
        .underflow(underflow), .hdr_err(hdr_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench-side show-ahead FIFO
    logic [DATA_W-1:0] fifo[$];
    logic              starve = 1'b0;
    logic              pop_pend = 1'b0;

    task automatic upd_fifo();
        word_valid = (fifo.size() > 0) && !starve;
        word_data  = (fifo.size() > 0) ? fifo[0] : '0;
    endtask

    // Per-scenario observations of the DUT
    logic [23:0] cap[$];
    int pops, pd_cnt, ad_cnt, uf_cnt, he_cnt, de_seen, last_pop, ad_pix;

    task automatic clr();
        cap.delete();
        pops = 0; pd_cnt = 0; ad_cnt = 0; uf_cnt = 0; he_cnt = 0;
        de_seen = 0; last_pop = 0; ad_pix = 0;
    endtask

    // Model: pattern state plus an absolute output-repeat index within the pattern
    int          m_st = 0;  // 0 idle, 1 waiting for frame, 2 streaming
    longint      m_total, m_pats, m_fill, m_out;
    logic        m_mode, m_inv;
    logic        m_prev_vs = 1'b1;
    logic        exp_ok = 1'b0;
    logic [31:0] exp_vec;

    task automatic model_step();
        logic        fs, e_rdy, e_pd, e_ad, e_uf, e_he;
        logic [23:0] e_rgb;
        logic [7:0]  bi, g;
        longint      p, n, r, k, f;
        fs = !m_prev_vs && pixel_vs;
        e_rdy = 1'b0; e_pd = 1'b0; e_ad = 1'b0; e_uf = 1'b0; e_he = 1'b0; e_rgb = '0;
        if (pixel_rst) begin
            m_st = 0;
            exp_ok = 1'b1;
            exp_vec = {1'b0, 1'b1, 1'b1, 24'h0, 5'b0};
        end else begin
            case (m_st)
                0: if (word_valid) begin
                    e_rdy   = 1'b1;
                    m_total = longint'(word_data[191 -: 32]);
                    m_pats  = longint'(word_data[159 -: 32]);
                    f       = longint'(word_data[103:96]);
                    m_fill  = (f == 0) ? 1 : f;
                    m_mode  = mode;
                    m_inv   = invert;
                    if (m_total == 0 || m_pats == 0) e_he = 1'b1;
                    else m_st = 1;
                end
                1: if (fs) begin
                    m_st  = 2;
                    m_out = 0;
                end
                default: if (pixel_de) begin
                    if (!word_valid) begin
                        e_uf = 1'b1;
                    end else begin
                        p = m_mode ? DATA_W / 8 : DATA_W;
                        n = m_out / m_fill;
                        r = m_out % m_fill;
                        k = n % p;
                        if (m_mode) begin
                            bi = 8'(255 - 8 * k);
                            g = word_data[bi -: 8];
                            e_rgb = {g, g, g};
                        end else begin
                            bi = 8'(255 - k);
                            e_rgb = word_data[bi] ? 24'h000000 : 24'hFFFFFF;
                        end
                        e_rgb = e_rgb ^ {24{m_inv}};
                        if (r == m_fill - 1 && (k == p - 1 || n == m_total - 1)) e_rdy = 1'b1;
                        if (m_out == m_total * m_fill - 1) begin
                            e_pd = 1'b1;
                            m_pats--;
                            if (m_pats == 0) begin
                                e_ad = 1'b1;
                                m_st = 0;
                            end else begin
                                m_st = 1;
                            end
                            m_out = 0;
                        end else begin
                            m_out++;
                        end
                    end
                end
            endcase
            exp_vec = {pixel_de, pixel_hs, pixel_vs, e_rgb, (m_st != 0), e_pd, e_ad, e_uf, e_he};
        end
        if (exp_ok) chk("word_ready", 64'(word_ready), 64'(e_rdy));
        if (pixel_de) de_seen++;
        pop_pend = word_valid && word_ready;
        if (pop_pend) begin
            pops++;
            last_pop = de_seen;
        end
        m_prev_vs = pixel_vs;
    endtask

    // Compare process: registered outputs at +1, FIFO pop at +1, model step at +4
    initial begin
        forever begin
            @(posedge pixel_clk);
            #1;
            if (exp_ok)
                chk("outputs",
                    64'({gen_de, gen_hs, gen_vs, gen_r, gen_g, gen_b,
                         busy, pattern_done, all_done, underflow, hdr_err}),
                    64'(exp_vec));
            if (gen_de) cap.push_back({gen_r, gen_g, gen_b});
            if (pattern_done) pd_cnt++;
            if (all_done) begin
                ad_cnt++;
                ad_pix = cap.size();
            end
            if (underflow) uf_cnt++;
            if (hdr_err) he_cnt++;
            if (pop_pend) begin
                void'(fifo.pop_front());
                pop_pend = 1'b0;
                upd_fifo();
            end
            #3;
            model_step();
        end
    end

    function automatic logic [DATA_W-1:0] hdr(input logic [31:0] t, input logic [31:0] p,
                                              input logic [31:0] f);
        return {32'd1920, 32'd1080, t, p, f, 96'd0};
    endfunction

    task automatic step();
        @(posedge pixel_clk);
        #2;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        fifo.push_back(w);
        upd_fifo();
    endtask

    task automatic run_frame(input int n_de, input int st_at, input int st_len, input int rst_at);
        pixel_de = 1'b0;
        pixel_vs = 1'b0;
        step(); step();
        pixel_vs = 1'b1;
        step(); step();
        for (int i = 0; i < n_de; i++) begin
            pixel_de  = 1'b1;
            pixel_hs  = (i % 16 != 0);
            starve    = (i >= st_at) && (i < st_at + st_len);
            pixel_rst = (i == rst_at);
            upd_fifo();
            step();
        end
        pixel_de = 1'b0; pixel_hs = 1'b1; starve = 1'b0; pixel_rst = 1'b0;
        upd_fifo();
        repeat (4) step();
    endtask

    logic [DATA_W-1:0] w_alt, w_gray;

    initial begin
        w_alt = {32{8'hAA}};
        w_gray = '0;
        for (int k = 0; k < 32; k++) w_gray = {w_gray[247:0], 8'(8'h40 + k)};

        // Reset with timing inputs active and a header already waiting
        pixel_rst = 1'b1; pixel_de = 1'b1; pixel_hs = 1'b0; pixel_vs = 1'b1;
        mode = 1'b0; invert = 1'b0;
        upd_fifo();
        push(hdr(256, 1, 0));
        push(w_alt);
        repeat (3) step();
        chk("rst_gen_de", 64'(gen_de), 64'(0));
        chk("rst_gen_hs", 64'(gen_hs), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_no_pop", 64'({word_valid, word_ready}), 64'(2'b10));

        // Mono single word
        clr();
        pixel_rst = 1'b0; pixel_de = 1'b0; pixel_hs = 1'b1;
        repeat (3) step();
        run_frame(256, 99999, 0, -1);
        chk("mono_pops", 64'(pops), 64'(2));
        chk("mono_npix", 64'(cap.size()), 64'(256));
        chk("mono_pix0", 64'(cap[0]), 64'(24'h000000));
        chk("mono_pix1", 64'(cap[1]), 64'(24'hFFFFFF));
        chk("mono_pix255", 64'(cap[255]), 64'(24'hFFFFFF));
        chk("mono_done", 64'({pd_cnt[7:0], ad_cnt[7:0]}), 64'(16'h0101));
        chk("mono_alldone_pix", 64'(ad_pix), 64'(256));
        chk("mono_idle", 64'(busy), 64'(0));

        // Replication and tail
        clr();
        push(hdr(300, 1, 3));
        push(w_alt);
        push('1);
        repeat (3) step();
        run_frame(900, 99999, 0, -1);
        chk("rep_pops", 64'(pops), 64'(3));
        chk("rep_last_pop_pix", 64'(last_pop), 64'(900));
        chk("rep_npix", 64'(cap.size()), 64'(900));
        chk("rep_pix2", 64'(cap[2]), 64'(24'h000000));
        chk("rep_pix3", 64'(cap[3]), 64'(24'hFFFFFF));
        chk("rep_pix767", 64'(cap[767]), 64'(24'hFFFFFF));
        chk("rep_pix768", 64'(cap[768]), 64'(24'h000000));
        chk("rep_alldone", 64'(ad_cnt), 64'(1));

        // Gray mode with invert, crossing a word boundary
        clr();
        mode = 1'b1; invert = 1'b1;
        push(hdr(33, 1, 1));
        push(w_gray);
        push('0);
        step();
        mode = 1'b0; invert = 1'b0;
        repeat (2) step();
        run_frame(33, 99999, 0, -1);
        chk("gray_pix0", 64'(cap[0]), 64'(24'hBFBFBF));
        chk("gray_pix31", 64'(cap[31]), 64'(24'hA0A0A0));
        chk("gray_pix32", 64'(cap[32]), 64'(24'hFFFFFF));
        chk("gray_pops", 64'(pops), 64'(3));
        chk("gray_last_pop_pix", 64'(last_pop), 64'(33));

        // Multi-pattern, one pattern per frame
        clr();
        push(hdr(256, 3, 0));
        push(w_alt);
        push('0);
        push('1);
        repeat (3) step();
        for (int f = 0; f < 3; f++) run_frame(256, 99999, 0, -1);
        chk("multi_pd", 64'(pd_cnt), 64'(3));
        chk("multi_ad", 64'(ad_cnt), 64'(1));
        chk("multi_pops", 64'(pops), 64'(4));
        chk("multi_pix256", 64'(cap[256]), 64'(24'hFFFFFF));
        chk("multi_pix512", 64'(cap[512]), 64'(24'h000000));
        chk("multi_idle", 64'(busy), 64'(0));

        // Starvation mid-word
        clr();
        push(hdr(256, 1, 0));
        push('0);
        repeat (3) step();
        run_frame(261, 100, 5, -1);
        chk("starve_uf", 64'(uf_cnt), 64'(5));
        chk("starve_pix99", 64'(cap[99]), 64'(24'hFFFFFF));
        chk("starve_pix100", 64'(cap[100]), 64'(24'h000000));
        chk("starve_pix104", 64'(cap[104]), 64'(24'h000000));
        chk("starve_pix105", 64'(cap[105]), 64'(24'hFFFFFF));
        chk("starve_ad_pix", 64'(ad_pix), 64'(261));

        // Rejected header
        clr();
        push(hdr(0, 1, 0));
        repeat (5) step();
        chk("hdr0_err", 64'(he_cnt), 64'(1));
        chk("hdr0_pops", 64'(pops), 64'(1));
        chk("hdr0_idle", 64'(busy), 64'(0));

        // Reset mid-stream: the leftover zero body word is then parsed as a (rejected) header
        clr();
        push(hdr(256, 1, 0));
        push('0);
        repeat (3) step();
        run_frame(256, 99999, 0, 100);
        chk("rstmid_npix", 64'(cap.size()), 64'(255));
        chk("rstmid_err", 64'(he_cnt), 64'(1));
        chk("rstmid_pops", 64'(pops), 64'(2));
        chk("rstmid_nodone", 64'(pd_cnt + ad_cnt), 64'(0));
        chk("rstmid_idle", 64'(busy), 64'(0));

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
